// File: rtl/spi_cmd_scheduler.sv
// rtl/spi_cmd_scheduler.sv - round-robin scheduler sharing one spi_master between command sources
module spi_cmd_scheduler #(
  parameter int N_REQ        = 4,
  parameter int PKT_W        = 18,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*PKT_W-1:0] pkt_in,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       err,
  output logic                   send,
  output logic [PKT_W-1:0]       data_out,
  input  logic                   busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE, RELEASE} state_t;

  state_t             state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      win;
  logic [IW-1:0]      pick;
  logic [IW-1:0]      off;
  logic [IW-1:0]      next_ptr;
  logic [IW:0]        sum;
  logic [CW-1:0]      cnt;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [N_REQ-1:0]   pick_oh;
  logic [PKT_W-1:0]   pick_pkt;

  // Rotate req so bit k is source (ptr+k) mod N_REQ; the lowest set bit is the winner.
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[ptr +: N_REQ];
    off     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) off = IW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
    pick = sum[IW-1:0];
  end

  always_comb begin
    pick_oh  = '0;
    pick_pkt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == IW'(i)) begin
        pick_oh[i] = 1'b1;
        pick_pkt   = pkt_in[i*PKT_W +: PKT_W];
      end
    end
    next_ptr = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
  end

  // done/err are driven on entry to RELEASE so they are high exactly for the RELEASE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      send     <= 1'b0;
      data_out <= '0;
      grant    <= '0;
      done     <= '0;
      err      <= '0;
      ptr      <= '0;
      win      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!busy && |req) begin
            grant    <= pick_oh;
            data_out <= pick_pkt;
            win      <= pick;
            send     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          send  <= 1'b0;
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
            err   <= grant;
            grant <= '0;
            ptr   <= next_ptr;
            state <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!busy) begin
            done  <= grant;
            grant <= '0;
            ptr   <= next_ptr;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          done  <= '0;
          err   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// tb/tb_spi_cmd_scheduler.sv - directed and randomized checks of spi_cmd_scheduler against a transaction-level model
module tb_spi_cmd_scheduler;

  localparam int N_REQ = 4;
  localparam int PKT_W = 18;
  localparam int BT    = 64;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*PKT_W-1:0] pkt_in;
  logic [N_REQ-1:0]       grant, done, err;
  logic                   send;
  logic [PKT_W-1:0]       data_out;
  logic                   busy;
  logic [PKT_W-1:0]       pkts [N_REQ];

  int vectors     = 0;
  int miscompares = 0;
  int ptr_m       = 0;

  spi_cmd_scheduler #(.N_REQ(N_REQ), .PKT_W(PKT_W), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .req(req), .pkt_in(pkt_in), .grant(grant), .done(done),
    .err(err), .send(send), .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    pkt_in = '0;
    for (int i = 0; i < N_REQ; i++) pkt_in[i*PKT_W +: PKT_W] = pkts[i];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N_REQ-1:0] r, input int p);
    for (int k = 0; k < N_REQ; k++) if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
    return 0;
  endfunction

  // One full transfer: expects send after exp_lat steps (0 = any), busy rises d steps after send, holds blen.
  task automatic serve(input int exp_lat, input int d, input int blen);
    int w, lat;
    logic [PKT_W-1:0] saved;
    w = rr_pick(req, ptr_m);
    lat = 0;
    while (send !== 1'b1 && lat < 8) begin step(); lat++; end
    chk("send_seen", 32'(send), 1);
    if (exp_lat > 0) chk("send_latency", lat, exp_lat);
    chk("grant", 32'(grant), 1 << w);
    chk("data_out", 32'(data_out), 32'(pkts[w]));
    saved = pkts[w];
    for (int i = 0; i < N_REQ; i++) pkts[i] = PKT_W'($urandom);
    step();
    chk("send_pulse_width", 32'(send), 0);
    repeat (d - 1) step();
    busy = 1'b1;
    for (int i = 0; i < blen; i++) begin
      step();
      chk("hold_done", 32'(done), 0);
      chk("hold_data", 32'(data_out), 32'(saved));
      chk("hold_grant", 32'(grant), 1 << w);
    end
    busy = 1'b0;
    step();
    chk("done", 32'(done), 1 << w);
    chk("err_on_done", 32'(err), 0);
    chk("grant_release", 32'(grant), 0);
    ptr_m = (w + 1) % N_REQ;
  endtask

  initial begin
    int c;
    bit done_seen;
    rst = 1'b1; busy = 1'b0; req = '0;
    for (int i = 0; i < N_REQ; i++) pkts[i] = '0;
    step(); step();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_send", 32'(send), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_data", 32'(data_out), 0);
    rst = 1'b0;

    // single request
    pkts[0] = {16'd250, 2'b01};
    req = 4'b0001;
    serve(1, 2, 40);
    step();
    chk("single_done_once", 32'(done), 0);
    req = '0;
    step();

    // busy hold-off
    busy = 1'b1; req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("holdoff_send", 32'(send), 0);
      chk("holdoff_grant", 32'(grant), 0);
    end
    busy = 1'b0;
    serve(1, 1, 5);

    // round robin with all sources requesting
    req = 4'b1111;
    for (int i = 0; i < N_REQ; i++) pkts[i] = PKT_W'($urandom);
    for (int t = 0; t < 5; t++) serve(2, $urandom_range(1, 6), $urandom_range(1, 12));

    // mid-queue release
    req = 4'b0101;
    serve(2, 2, 4);
    req = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("release_no_send", 32'(send), 0);
      chk("release_no_grant", 32'(grant), 0);
    end

    // busy-rise timeout
    req = 4'b0010;
    c = 0;
    while (send !== 1'b1 && c < 8) begin step(); c++; end
    chk("to_send", 32'(send), 1);
    chk("to_grant", 32'(grant), 4'b0010);
    c = 0; done_seen = 1'b0;
    while (err === '0 && c < 100) begin
      step(); c++;
      if (done !== '0) done_seen = 1'b1;
    end
    chk("to_cycles", c, BT + 1);
    chk("to_err", 32'(err), 4'b0010);
    chk("to_no_done", 32'(done_seen), 0);
    chk("to_grant_clear", 32'(grant), 0);
    ptr_m = 2;
    req = 4'b0011;
    serve(2, 3, 6);

    // reset during WAIT_DONE
    req = 4'b0100;
    c = 0;
    while (send !== 1'b1 && c < 8) begin step(); c++; end
    step(); busy = 1'b1;
    step(); step(); step();
    rst = 1'b1;
    #1;
    chk("arst_send", 32'(send), 0);
    chk("arst_grant", 32'(grant), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_data", 32'(data_out), 0);
    step();
    busy = 1'b0; rst = 1'b0; req = 4'b1001; ptr_m = 0;
    serve(1, 2, 3);

    // randomized traffic
    for (int t = 0; t < 25; t++) begin
      req = 4'($urandom_range(1, 15));
      serve(2, $urandom_range(1, 8), $urandom_range(1, 30));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
